// File: rtl/keypad_scan_module_if.sv
// Keypad matrix pins and decoded key outputs of the keypad scanner.
// The scanner connects as slave; the set/mode controller and keypad side connect as master.
interface keypad_scan_module_if;
    logic [3:0] KeyRow_In;
    logic [3:0] KeyCol_Out;
    logic [3:0] KeyCode;
    logic       KeyValid;
    logic       KeyHeld;

    modport slave (
        input  KeyRow_In,
        output KeyCol_Out,
        output KeyCode,
        output KeyValid,
        output KeyHeld
    );

    modport master (
        output KeyRow_In,
        input  KeyCol_Out,
        input  KeyCode,
        input  KeyValid,
        input  KeyHeld
    );
endinterface

// File: rtl/keypad_scan_module.sv
// 4x4 active-low keypad scanner: rotating column strobe, per-frame classification,
// frame-based press/release debounce producing a one-cycle KeyValid and a KeyHeld level.
//
//   state      | meaning
//   -----------+---------------------------------------------------------------
//   S_IDLE     | no key accepted, waiting for a single-key frame
//   S_DEBOUNCE | counting consecutive frames showing the same single key (cand)
//   S_PRESSED  | key accepted, KeyHeld high, waiting for an empty frame
//   S_RELEASE  | counting consecutive empty frames before dropping KeyHeld
module keypad_scan_module #(
    parameter int SCAN_DIV       = 200,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    keypad_scan_module_if.slave  kp
);

    localparam int              DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]   DWELL_TC   = DW'(SCAN_DIV - 1);
    localparam logic [4:0]      DEB_TARGET = 5'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    logic [3:0]    row_meta_q;
    logic [3:0]    row_sync_q;

    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    col_out_q, col_out_d;
    logic          dwell_tc;
    logic          frame_end;

    logic [3:0]    row_act;
    logic [2:0]    row_cnt;
    logic [1:0]    row_idx;
    logic [1:0]    hits_q, hits_d;
    logic [3:0]    fcode_q, fcode_d;
    logic [2:0]    hits_sum;
    logic          frame_none;
    logic          frame_single;
    logic [3:0]    frame_code;

    state_t        state_q, state_d;
    logic [3:0]    dcnt_q, dcnt_d;
    logic [4:0]    dcnt_inc;
    logic [3:0]    cand_q, cand_d;

    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    // Rows come straight from the keypad pins and are asynchronous to CLK.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
        end else begin
            row_meta_q <= kp.KeyRow_In;
            row_sync_q <= row_meta_q;
        end
    end

    assign dwell_tc  = (dwell_q == DWELL_TC);
    assign frame_end = dwell_tc && (col_q == 2'd3);

    always_comb begin
        dwell_d   = dwell_tc ? '0 : dwell_q + DW'(1);
        col_d     = dwell_tc ? col_q + 2'd1 : col_q;
        col_out_d = ~(4'b1000 >> col_d);
    end

    // Strobe is registered so the pins never glitch while the index changes.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            dwell_q   <= '0;
            col_q     <= 2'd0;
            col_out_q <= 4'b0111;
        end else begin
            dwell_q   <= dwell_d;
            col_q     <= col_d;
            col_out_q <= col_out_d;
        end
    end

    assign row_act = ~row_sync_q;
    assign row_cnt = 3'($countones(row_act));

    always_comb begin
        row_idx = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (row_act[r]) row_idx = 2'(r);
        end
    end

    // Hit count saturates at 2: only none / one / many matters to the classifier.
    assign hits_sum     = {1'b0, hits_q} + row_cnt;
    assign frame_none   = (hits_sum == 3'd0);
    assign frame_single = (hits_sum == 3'd1);
    assign frame_code   = (row_cnt == 3'd1) ? {col_q, row_idx} : fcode_q;

    always_comb begin
        hits_d  = hits_q;
        fcode_d = fcode_q;
        if (dwell_tc) begin
            if (col_q == 2'd3) begin
                hits_d  = 2'd0;
                fcode_d = 4'd0;
            end else begin
                hits_d  = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
                fcode_d = frame_code;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            hits_q  <= 2'd0;
            fcode_q <= 4'd0;
        end else begin
            hits_q  <= hits_d;
            fcode_q <= fcode_d;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= S_IDLE;
            dcnt_q      <= 4'd0;
            cand_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign dcnt_inc = {1'b0, dcnt_q} + 5'd1;

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        cand_d  = cand_q;
        if (frame_end) begin
            case (state_q)
                S_IDLE: begin
                    if (frame_single) begin
                        state_d = S_DEBOUNCE;
                        cand_d  = frame_code;
                        dcnt_d  = 4'd1;
                    end
                end
                S_DEBOUNCE: begin
                    if (frame_single && (frame_code == cand_q)) begin
                        if (dcnt_inc == DEB_TARGET) begin
                            state_d = S_PRESSED;
                            dcnt_d  = 4'd0;
                        end else begin
                            dcnt_d  = dcnt_inc[3:0];
                        end
                    end else if (frame_single) begin
                        cand_d  = frame_code;
                        dcnt_d  = 4'd1;
                    end else begin
                        state_d = S_IDLE;
                        dcnt_d  = 4'd0;
                    end
                end
                S_PRESSED: begin
                    if (frame_none) begin
                        state_d = S_RELEASE;
                        dcnt_d  = 4'd1;
                    end
                end
                S_RELEASE: begin
                    if (!frame_none) begin
                        state_d = S_PRESSED;
                        dcnt_d  = 4'd0;
                    end else if (dcnt_inc == DEB_TARGET) begin
                        state_d = S_IDLE;
                        dcnt_d  = 4'd0;
                    end else begin
                        dcnt_d  = dcnt_inc[3:0];
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    dcnt_d  = 4'd0;
                end
            endcase
        end
    end

    // Outputs follow the accept / release transitions only; returning from
    // RELEASE to PRESSED leaves them untouched, so a press never re-fires.
    always_comb begin
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        key_code_d  = key_code_q;
        if (state_q == S_DEBOUNCE && state_d == S_PRESSED) begin
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            key_code_d  = cand_q;
        end else if (state_q == S_RELEASE && state_d == S_IDLE) begin
            key_held_d  = 1'b0;
        end
    end

    assign kp.KeyCol_Out = col_out_q;
    assign kp.KeyCode    = key_code_q;
    assign kp.KeyValid   = key_valid_q;
    assign kp.KeyHeld    = key_held_q;

endmodule
